clk_gate_seq: RTL
=================

// Module: clk_gate_seq
// PURPOSE
// - Responder side of the per-peripheral clock-request interface driven by the power-state controller.
// - Per channel: turns clk_req into a sequenced clock-gate enable (gate_en) and an acknowledge (clk_ack).
// - Sequencing: staggered wake-up (inrush limit), a settle delay, and off-hysteresis that a busy peripheral can block.
// - Sits between the power FSMs and the integrated clock-gating cells.
// PARAMETERS
// N         4  number of peripheral channels (>=1)
// ON_DLY    2  cycles gate_en is high before clk_ack asserts (clock settle), >=1
// OFF_HOLD  8  consecutive idle cycles in HOLD before gating, >=1
// MAX_WAKE  1  max channels simultaneously in WAKING (1..N)
// PORTS
// clk       in   1        clock
// rst_n     in   1        reset, asynchronous, active-low
// clk_req   in   N        per-channel clock request (1 = clock wanted)
// busy      in   N        per-channel outstanding-transaction flag; blocks gating
// gate_en   out  N        ICG enable, registered
// clk_ack   out  N        clock stable and usable, registered
// ch_state  out  N*2      per-channel state: OFF=00, WAKING=01, ON=10, HOLD=11
// all_off   out  1        registered; 1 when every channel is OFF
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all channels OFF; gate_en=0, clk_ack=0, all_off=1.
//   - round-robin pointer rr_ptr=0; all counters 0.
//   - Mid-operation reset drops gate_en/clk_ack immediately, regardless of state.
// - Output decode (all registered, updated with state):
//   - gate_en = (state != OFF).
//   - clk_ack = (state == ON or HOLD).
// - Per-channel FSM:
//   - OFF -> WAKING: clk_req=1 and the channel is granted (see arbitration); counter loads ON_DLY.
//   - WAKING: counter decrements each cycle; -> ON on the cycle after the counter reaches 1.
//     - Always completes, even if clk_req drops; the channel then follows the ON path.
//     - Timing: clk_req sampled high at cycle t -> gate_en=1 at t+1, clk_ack=1 at t+1+ON_DLY.
//   - ON -> HOLD: clk_req=0 and busy=0 sampled; counter loads OFF_HOLD. Otherwise stay ON (busy=1 keeps ON).
//   - HOLD:
//     - clk_req=1 -> ON next cycle; clk_ack never deasserts.
//     - else busy=1 -> stay HOLD, counter reloads OFF_HOLD.
//     - else counter decrements; -> OFF after OFF_HOLD consecutive idle HOLD cycles.
//     - Timing: idle from ON at cycle t -> HOLD t+1..t+OFF_HOLD, OFF at t+OFF_HOLD+1.
//   - Illegal encodings cannot occur with a 2-bit, 4-state encoding; no recovery path is needed.
// - Wake arbitration:
//   - Candidates: channels in OFF with clk_req=1.
//   - At most one grant per cycle, and only when the count of channels currently in WAKING < MAX_WAKE.
//     The count uses current-cycle state; a channel leaving WAKING this cycle still counts.
//   - Search starts at rr_ptr and ascends with wrap-around. On a grant to channel g, rr_ptr <= (g+1) mod N.
//   - rr_ptr is unchanged when there is no grant. An ungranted request waits in OFF; no loss, no timeout.
// - all_off: registered AND of (next state == OFF) across channels, so it tracks ch_state in the same cycle.
// - Simultaneous events: clk_req and busy are both don't-care in WAKING. In HOLD, clk_req has priority over busy.
// - Counter width: $clog2(max(ON_DLY,OFF_HOLD)+1). One counter per channel, shared by WAKING and HOLD.
// TESTING
// - Reset: assert rst_n=0 mid-run with ch0 WAKING -> gate_en=0, clk_ack=0, ch_state=0, all_off=1 before the next clk edge; rr_ptr=0 after release.
// - Wake latency, ON_DLY=2: clk_req[0] 0->1 sampled at cycle 0 -> gate_en[0]=1 at 1, clk_ack[0]=1 at 3, all_off=0 at 1.
// - Arbitration, MAX_WAKE=1, ON_DLY=2:
//   - clk_req=4'b1111 at cycle 0 -> ch0 WAKING at 1, ON at 3.
//   - ch1 WAKING at 4, ch2 at 7, ch3 at 10; never two channels WAKING at once.
// - Hysteresis, OFF_HOLD=8:
//   - ch0 ON, clk_req drops at cycle 0 -> HOLD 1..8, OFF at 9.
//   - Repeat with clk_req re-raised at cycle 4 -> ON at 5; clk_ack stays 1 throughout.
// - Busy block: ch1 ON, clk_req=0, busy=1 for 20 cycles -> stays ON; busy drops at cycle 20 -> HOLD 21..28, OFF at 29.
// - Req drop during WAKING: clk_req[2] is a single-cycle pulse -> WAKING, ON, HOLD, then OFF after OFF_HOLD; gate_en stays high the whole time.

Source files
------------

// File: rtl/clk_gate_seq.sv
// Per-channel clock-request responder: sequences ICG enables and acknowledges with
// staggered round-robin wake-up, a settle delay, and busy-blockable off-hysteresis.
module clk_gate_seq #(
    parameter int N        = 4,
    parameter int ON_DLY   = 2,
    parameter int OFF_HOLD = 8,
    parameter int MAX_WAKE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     clk_req,
    input  logic [N-1:0]     busy,
    output logic [N-1:0]     gate_en,
    output logic [N-1:0]     clk_ack,
    output logic [2*N-1:0]   ch_state,
    output logic             all_off
);

    localparam int CMAX = (ON_DLY > OFF_HOLD) ? ON_DLY : OFF_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int WW   = $clog2(N + 1);

    localparam logic [1:0] ST_OFF    = 2'b00;
    localparam logic [1:0] ST_WAKING = 2'b01;
    localparam logic [1:0] ST_ON     = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;

    logic [1:0]    state_q [N];
    logic [1:0]    state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]  gate_en_q, gate_en_d;
    logic [N-1:0]  clk_ack_q, clk_ack_d;
    logic          all_off_q, all_off_d;

    logic [WW-1:0]  waking_cnt;
    logic [N-1:0]   cand;
    logic [2*N-1:0] cand_rot;
    logic           grant_vld;
    logic [PW-1:0]  grant_idx;
    logic [PW:0]    grant_sum;
    logic [PW:0]    rr_next;

    // Wake arbiter: rotate candidates so bit 0 is rr_ptr, take the lowest set bit.
    always_comb begin : arb
        waking_cnt = '0;
        cand       = '0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_sum  = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q[i] == ST_WAKING) waking_cnt = waking_cnt + WW'(1);
            cand[i] = clk_req[i] && (state_q[i] == ST_OFF);
        end
        cand_rot = {cand, cand} >> rr_ptr_q;
        if (waking_cnt < WW'(MAX_WAKE)) begin
            for (int k = 0; k < N; k++) begin
                if (!grant_vld && cand_rot[k]) begin
                    grant_vld = 1'b1;
                    grant_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
                    if (grant_sum >= (PW+1)'(N)) grant_sum = grant_sum - (PW+1)'(N);
                    grant_idx = grant_sum[PW-1:0];
                end
            end
        end
    end

    always_comb begin : fsm_next
        rr_next  = {1'b0, grant_idx} + (PW+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) rr_ptr_d = (rr_next == (PW+1)'(N)) ? '0 : rr_next[PW-1:0];
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (grant_vld && (grant_idx == PW'(i))) begin
                        state_d[i] = ST_WAKING;
                        cnt_d[i]   = CW'(ON_DLY);
                    end
                end
                ST_WAKING: begin
                    if (cnt_q[i] == CW'(1)) state_d[i] = ST_ON;
                    else                    cnt_d[i]   = cnt_q[i] - CW'(1);
                end
                ST_ON: begin
                    if (!clk_req[i] && !busy[i]) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = CW'(OFF_HOLD);
                    end
                end
                default: begin
                    // HOLD: a renewed request wins over busy
                    if (clk_req[i])               state_d[i] = ST_ON;
                    else if (busy[i])             cnt_d[i]   = CW'(OFF_HOLD);
                    else if (cnt_q[i] == CW'(1)) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else                      cnt_d[i]   = cnt_q[i] - CW'(1);
                end
            endcase
        end
    end

    always_comb begin : out_next
        gate_en_d = '0;
        clk_ack_d = '0;
        all_off_d = 1'b1;
        for (int i = 0; i < N; i++) begin
            gate_en_d[i] = (state_d[i] != ST_OFF);
            clk_ack_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
            if (state_d[i] != ST_OFF) all_off_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            rr_ptr_q  <= '0;
            gate_en_q <= '0;
            clk_ack_q <= '0;
            all_off_q <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_ptr_q  <= rr_ptr_d;
            gate_en_q <= gate_en_d;
            clk_ack_q <= clk_ack_d;
            all_off_q <= all_off_d;
        end
    end

    always_comb begin
        ch_state = '0;
        for (int i = 0; i < N; i++) ch_state[2*i +: 2] = state_q[i];
    end

    assign gate_en = gate_en_q;
    assign clk_ack = clk_ack_q;
    assign all_off = all_off_q;

endmodule
